gpio_irq: RTL and testbench
===========================

Name: gpio_irq

Overview:
- Parametrised next-generation GPIO peripheral on the CPU memory bus.
- Provides per-pin output enable and data out, with set, clear and toggle aliases.
- Adds synchronised inputs, per-pin rising/falling edge detection, a sticky write-1-to-clear interrupt status, and a single registered interrupt line to the CPU.
- Sits beside the other bus slaves; the address decoder drives mem_sel.

Parameters:
- NR_GPIOS, 8: number of pins, legal range 1..32.
- SYNC_STAGES, 2: gpio_di synchroniser depth, legal range 2..4.
- OE_RESET, 0: reset value of gpio_oe, NR_GPIOS bits.
- DO_RESET, 0: reset value of gpio_do, NR_GPIOS bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- mem_sel  input  1  block selected by address decoder
- mem_valid  input  1  bus request valid
- mem_ready  output  1  request accepted/completed
- mem_wr  input  1  1 = write, 0 = read
- mem_addr  input  12  byte address; only [5:2] decoded
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data
- gpio_oe  output  NR_GPIOS  per-pin output enable
- gpio_do  output  NR_GPIOS  per-pin output data
- gpio_di  input  NR_GPIOS  asynchronous pin inputs
- irq  output  1  level interrupt, active-high

Behaviour:
- Reset (asynchronous, active-high) forces:
  - gpio_oe=OE_RESET, gpio_do=DO_RESET.
  - mem_ready=0, mem_rdata=0, irq=0.
  - IRQ_EN, RISE_EN, FALL_EN, STATUS, synchroniser chain and din_prev all 0.
- Reset mid-transaction drops the access with no register side effects; the master must reissue it.
- Access: defined by mem_sel & mem_valid & !mem_ready.
  - Writes commit on that clock edge.
  - mem_ready is 1 on the following cycle only, then 0 again, so every access takes exactly 2 cycles.
  - mem_rdata is registered on the same edge, valid while mem_ready=1, and 0 at all other times.
- A request with mem_sel=0 is ignored: no ready, no write.
- Register map, byte offset = {mem_addr[5:2],2'b00}, upper bits [31:NR_GPIOS] read 0:
  - 0x00 CONFIG, RW: gpio_oe.
  - 0x04 DOUT, RW: gpio_do.
  - 0x08 DOUT_SET, WO: gpio_do |= wdata.
  - 0x0C DOUT_CLR, WO: gpio_do &= ~wdata.
  - 0x10 DOUT_TGL, WO: gpio_do ^= wdata.
  - 0x14 DIN, RO: synchronised inputs (din).
  - 0x18 IRQ_EN, RW: per-pin interrupt enable.
  - 0x1C RISE_EN, RW: rising-edge detect enable.
  - 0x20 FALL_EN, RW: falling-edge detect enable.
  - 0x24 STATUS, R/W1C: sticky edge flags.
  - 0x28 INFO, RO: [7:0]=NR_GPIOS, [11:8]=SYNC_STAGES.
- Write-only registers read 0. Unmapped offsets read 0 and ignore writes.
- Synchroniser: gpio_di passes through SYNC_STAGES flops; the last stage is din, and din_prev is din delayed one cycle.
- Edge event per pin:
  - rise = din & ~din_prev & RISE_EN.
  - fall = ~din & din_prev & FALL_EN.
  - If both enables are set, either edge sets the flag.
  - Edges are detected regardless of IRQ_EN.
- STATUS update each cycle: STATUS <= (STATUS & ~w1c) | event, where w1c is wdata on a committed STATUS write and 0 otherwise.
  - An event in the same cycle as its clear wins, so the bit stays 1.
- irq <= |(STATUS & IRQ_EN), registered.
  - Enabling IRQ_EN on an already-set STATUS bit raises irq one cycle after the write commits.
- Latency: a gpio_di change stable from edge k appears on din after edge k+SYNC_STAGES-1, sets STATUS at edge k+SYNC_STAGES, and asserts irq at edge k+SYNC_STAGES+1.
- Pulses shorter than one clock may be missed. This is not an error.
- Wdata bits above NR_GPIOS-1 are ignored. gpio_di is never combinationally visible on mem_rdata.

Test Plan:
- Reset, then read CONFIG/DOUT/STATUS/INFO -> OE_RESET, DO_RESET, 0, 0x208 (defaults); mem_ready high exactly 1 cycle per access; irq=0.
- Write DOUT=0xA5, then SET 0x0F, CLR 0x81, TGL 0xFF -> gpio_do goes 0xA5, 0xAF, 0x2E, 0xD1; read DOUT=0xD1; writes with mem_sel=0 leave gpio_do unchanged and give no ready.
- RISE_EN=0x01, IRQ_EN=0x01, drive gpio_di[0] 0->1 -> DIN bit0=1 after 2 edges, STATUS=0x01 at edge 2, irq=1 at edge 3; falling edge on pin 0 sets nothing.
- With STATUS=0x01, write STATUS=0x01 -> STATUS=0, irq drops the next cycle; repeat with a new rising edge arriving the same cycle as the W1C -> STATUS stays 0x01 and irq stays 1.
- FALL_EN=0x80, IRQ_EN=0, pin 7 falls -> STATUS=0x80, irq=0; then write IRQ_EN=0x80 -> irq=1 one cycle after commit.
- Assert reset mid-access (valid high, before ready) with STATUS=0xFF -> mem_ready=0, STATUS=0, irq=0 immediately (asynchronously); the reissued access completes normally.

Source files
------------

// File: rtl/gpio_irq.sv
// gpio_irq: bus-mapped GPIO with set/clear/toggle aliases, synchronised inputs,
// per-pin edge detection, sticky W1C status and a registered interrupt line.
module gpio_irq #(
    parameter int                  NR_GPIOS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NR_GPIOS-1:0] OE_RESET    = '0,
    parameter logic [NR_GPIOS-1:0] DO_RESET    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_sel,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic                mem_wr,
    input  logic [11:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    output logic [31:0]         mem_rdata,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic [NR_GPIOS-1:0] gpio_do,
    input  logic [NR_GPIOS-1:0] gpio_di,
    output logic                irq
);
    localparam logic [3:0] A_CONFIG = 4'h0;
    localparam logic [3:0] A_DOUT   = 4'h1;
    localparam logic [3:0] A_SET    = 4'h2;
    localparam logic [3:0] A_CLR    = 4'h3;
    localparam logic [3:0] A_TGL    = 4'h4;
    localparam logic [3:0] A_DIN    = 4'h5;
    localparam logic [3:0] A_IEN    = 4'h6;
    localparam logic [3:0] A_REN    = 4'h7;
    localparam logic [3:0] A_FEN    = 4'h8;
    localparam logic [3:0] A_STATUS = 4'h9;
    localparam logic [3:0] A_INFO   = 4'hA;

    logic [NR_GPIOS-1:0] oe_q, oe_d, do_q, do_d, ien_q, ien_d, ren_q, ren_d;
    logic [NR_GPIOS-1:0] fen_q, fen_d, st_q, st_d, din_prev_q;
    logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
    logic                ready_q, irq_q, irq_d;
    logic [31:0]         rdata_q, rdata_d, rd;
    logic                acc, wr;
    logic [3:0]          off;
    logic [NR_GPIOS-1:0] wd, din, evt, w1c;
    logic                unused_bits;

    assign acc         = mem_sel & mem_valid & ~ready_q;
    assign wr          = acc & mem_wr;
    assign off         = mem_addr[5:2];
    assign wd          = mem_wdata[NR_GPIOS-1:0];
    assign din         = sync_q[SYNC_STAGES-1];
    assign evt         = (din & ~din_prev_q & ren_q) | (~din & din_prev_q & fen_q);
    assign unused_bits = ^{mem_addr[11:6], mem_addr[1:0], mem_wdata};

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign gpio_oe   = oe_q;
    assign gpio_do   = do_q;
    assign irq       = irq_q;

    always_comb begin
        oe_d  = (wr && off == A_CONFIG) ? wd : oe_q;
        do_d  = !wr               ? do_q :
                off == A_DOUT     ? wd :
                off == A_SET      ? do_q | wd :
                off == A_CLR      ? do_q & ~wd :
                off == A_TGL      ? do_q ^ wd : do_q;
        ien_d = (wr && off == A_IEN) ? wd : ien_q;
        ren_d = (wr && off == A_REN) ? wd : ren_q;
        fen_d = (wr && off == A_FEN) ? wd : fen_q;
        // a same-cycle event overrides its own clear
        w1c   = (wr && off == A_STATUS) ? wd : '0;
        st_d  = (st_q & ~w1c) | evt;
        irq_d = |(st_q & ien_q);
        case (off)
            A_CONFIG: rd = 32'(oe_q);
            A_DOUT:   rd = 32'(do_q);
            A_DIN:    rd = 32'(din);
            A_IEN:    rd = 32'(ien_q);
            A_REN:    rd = 32'(ren_q);
            A_FEN:    rd = 32'(fen_q);
            A_STATUS: rd = 32'(st_q);
            A_INFO:   rd = {20'd0, 4'(SYNC_STAGES), 8'(NR_GPIOS)};
            default:  rd = '0;
        endcase
        rdata_d = (acc && !mem_wr) ? rd : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oe_q       <= OE_RESET;
            do_q       <= DO_RESET;
            ien_q      <= '0;
            ren_q      <= '0;
            fen_q      <= '0;
            st_q       <= '0;
            din_prev_q <= '0;
            sync_q     <= '{default: '0};
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            oe_q       <= oe_d;
            do_q       <= do_d;
            ien_q      <= ien_d;
            ren_q      <= ren_d;
            fen_q      <= fen_d;
            st_q       <= st_d;
            din_prev_q <= din;
            sync_q[0]  <= gpio_di;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            ready_q    <= acc;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed stimulus against a cycle model of the register map,
// with per-cycle output comparison plus hand-computed literal checks.
module tb_gpio_irq;
    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 0;
    logic         reset = 1;
    logic         mem_sel = 0, mem_valid = 0, mem_wr = 0;
    logic [11:0]  mem_addr = '0;
    logic [31:0]  mem_wdata = '0;
    logic [N-1:0] gpio_di = '0;
    logic         mem_ready, irq;
    logic [31:0]  mem_rdata;
    logic [N-1:0] gpio_oe, gpio_do;

    int checks = 0;
    int failures = 0;

    gpio_irq #(.NR_GPIOS(N), .SYNC_STAGES(S), .OE_RESET('0), .DO_RESET('0)) dut (
        .clk(clk), .reset(reset), .mem_sel(mem_sel), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gpio_oe(gpio_oe),
        .gpio_do(gpio_do), .gpio_di(gpio_di), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: din is simply the pin value sampled S edges earlier, kept as a history.
    logic [N-1:0] m_oe = '0, m_do = '0, m_ien = '0, m_ren = '0, m_fen = '0, m_st = '0;
    logic         m_irq = 0, m_rdy = 0;
    logic [31:0]  m_rdata = '0;
    logic [N-1:0] hist [64] = '{default: '0};
    int           cyc = 0;
    logic [N-1:0] m_dn, m_dp, m_ev, m_wd;
    logic         m_a, m_w;
    int           m_off;

    function automatic logic [31:0] mrd(input int o, input logic [N-1:0] dn);
        case (o)
            0:  return 32'(m_oe);
            4:  return 32'(m_do);
            20: return 32'(dn);
            24: return 32'(m_ien);
            28: return 32'(m_ren);
            32: return 32'(m_fen);
            36: return 32'(m_st);
            40: return 32'(N) | (32'(S) << 8);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_oe = '0; m_do = '0; m_ien = '0; m_ren = '0; m_fen = '0; m_st = '0;
            m_irq = 0; m_rdy = 0; m_rdata = '0; cyc = 0;
            for (int i = 0; i < 64; i++) hist[i] = '0;
        end else begin
            m_dn = hist[(cyc - S) & 63];
            m_dp = hist[(cyc - S - 1) & 63];
            hist[cyc & 63] = gpio_di;
            cyc++;
            m_a   = mem_sel & mem_valid & !m_rdy;
            m_w   = m_a & mem_wr;
            m_off = int'(mem_addr[5:2]) * 4;
            m_wd  = mem_wdata[N-1:0];
            m_rdata = (m_a && !mem_wr) ? mrd(m_off, m_dn) : 32'd0;
            m_irq = |(m_st & m_ien);
            m_ev  = (m_dn & ~m_dp & m_ren) | (~m_dn & m_dp & m_fen);
            m_st  = (m_st & ~((m_w && m_off == 36) ? m_wd : '0)) | m_ev;
            if (m_w)
                case (m_off)
                    0:  m_oe = m_wd;
                    4:  m_do = m_wd;
                    8:  m_do = m_do | m_wd;
                    12: m_do = m_do & ~m_wd;
                    16: m_do = m_do ^ m_wd;
                    24: m_ien = m_wd;
                    28: m_ren = m_wd;
                    32: m_fen = m_wd;
                    default: ;
                endcase
            m_rdy = m_a;
        end
    end

    always @(negedge clk) begin
        chk("mdl_ready", 32'(mem_ready), 32'(m_rdy));
        chk("mdl_rdata", mem_rdata, m_rdata);
        chk("mdl_oe", 32'(gpio_oe), 32'(m_oe));
        chk("mdl_do", 32'(gpio_do), 32'(m_do));
        chk("mdl_irq", 32'(irq), 32'(m_irq));
    end

    task automatic bus(input logic w, input logic [5:0] off, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        mem_sel = 1; mem_valid = 1; mem_wr = w; mem_addr = {6'd0, off}; mem_wdata = d;
        @(negedge clk);
        chk("bus_ready", 32'(mem_ready), 32'd1);
        r = mem_rdata;
        mem_sel = 0; mem_valid = 0; mem_wr = 0;
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, off, d, r);
    endtask

    task automatic rd(input string name, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, off, 32'd0, r);
        chk(name, r, exp);
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ncyc(2);
        reset = 0;
        rd("rst_config", 6'h00, 32'h0);
        rd("rst_dout", 6'h04, 32'h0);
        rd("rst_status", 6'h24, 32'h0);
        rd("rst_info", 6'h28, 32'h208);
        chk("rst_irq", 32'(irq), 32'd0);

        wr(6'h04, 32'hA5); chk("do_write", 32'(gpio_do), 32'hA5);
        wr(6'h08, 32'h0F); chk("do_set", 32'(gpio_do), 32'hAF);
        wr(6'h0C, 32'h81); chk("do_clr", 32'(gpio_do), 32'h2E);
        wr(6'h10, 32'hFF); chk("do_tgl", 32'(gpio_do), 32'hD1);
        rd("do_read", 6'h04, 32'hD1);
        rd("wo_set_reads0", 6'h08, 32'h0);
        @(negedge clk);
        mem_sel = 0; mem_valid = 1; mem_wr = 1; mem_addr = 12'h004; mem_wdata = 32'h0;
        @(negedge clk);
        chk("nosel_ready", 32'(mem_ready), 32'd0);
        chk("nosel_do", 32'(gpio_do), 32'hD1);
        mem_valid = 0; mem_wr = 0;

        wr(6'h1C, 32'h01);
        wr(6'h18, 32'h01);
        gpio_di[0] = 1;
        ncyc(1); chk("rise_irq_k0", 32'(irq), 32'd0);
        ncyc(1); chk("rise_irq_k1", 32'(irq), 32'd0);
        ncyc(1); chk("rise_irq_k2", 32'(irq), 32'd0);
        ncyc(1); chk("rise_irq_k3", 32'(irq), 32'd1);
        rd("rise_status", 6'h24, 32'h01);
        rd("rise_din", 6'h14, 32'h01);
        gpio_di[0] = 0;
        ncyc(5);
        rd("fall_ignored", 6'h24, 32'h01);

        wr(6'h24, 32'h01); chk("w1c_irq_same", 32'(irq), 32'd1);
        ncyc(1); chk("w1c_irq_drop", 32'(irq), 32'd0);
        rd("w1c_status", 6'h24, 32'h0);
        gpio_di[0] = 1; ncyc(4);
        gpio_di[0] = 0; ncyc(4);
        chk("pre_race_irq", 32'(irq), 32'd1);
        gpio_di[0] = 1;
        ncyc(1);
        wr(6'h24, 32'h01); chk("race_irq0", 32'(irq), 32'd1);
        ncyc(1); chk("race_irq1", 32'(irq), 32'd1);
        rd("race_status", 6'h24, 32'h01);

        wr(6'h24, 32'h01);
        wr(6'h18, 32'h00);
        wr(6'h20, 32'h80);
        gpio_di[7] = 1; ncyc(4);
        gpio_di[7] = 0; ncyc(4);
        rd("fall7_status", 6'h24, 32'h80);
        chk("fall7_irq", 32'(irq), 32'd0);
        wr(6'h18, 32'h80); chk("ien_late_irq0", 32'(irq), 32'd0);
        ncyc(1); chk("ien_late_irq1", 32'(irq), 32'd1);

        wr(6'h1C, 32'hFF);
        gpio_di = '0; ncyc(4);
        gpio_di = '1; ncyc(4);
        rd("all_status", 6'h24, 32'hFF);
        @(negedge clk);
        mem_sel = 1; mem_valid = 1; mem_wr = 1; mem_addr = 12'h000; mem_wdata = 32'h55;
        #2 reset = 1;
        #1;
        chk("arst_ready", 32'(mem_ready), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_do", 32'(gpio_do), 32'd0);
        @(negedge clk);
        chk("arst_oe", 32'(gpio_oe), 32'd0);
        mem_sel = 0; mem_valid = 0; mem_wr = 0;
        reset = 0;
        wr(6'h00, 32'h55); chk("reissue_oe", 32'(gpio_oe), 32'h55);
        rd("reissue_status", 6'h24, 32'h0);
        rd("unmapped", 6'h3C, 32'h0);
        chk("end_irq", 32'(irq), 32'd0);
        ncyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
